fetch_decode_buffer: RTL
========================

FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the width of PC and instruction fields.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, giving the value driven on out_instr when no entry is valid.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, fetch stage presents a fetched instruction this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit, the buffer accepts an entry this cycle.
REQ-007 SHALL have port in_pc, input, XLEN, address of the fetched instruction (fetch PC register value).
REQ-008 SHALL have port in_pc_plus4, input, XLEN, fetch adder output (in_pc + 4).
REQ-009 SHALL have port in_instr, input, XLEN, instruction word read from instruction memory.
REQ-010 SHALL have port out_valid, output, 1 bit, head entry is valid for decode.
REQ-011 SHALL have port out_ready, input, 1 bit, decode consumes the head entry this cycle.
REQ-012 SHALL have ports out_pc, out_pc_plus4 and out_instr, each an XLEN-bit output, the fields of the head entry.
REQ-013 SHALL have port flush, input, 1 bit, discards all entries (taken branch/jump redirect).
REQ-014 SHALL have port occupancy, output, 2 bits, number of valid entries (0..2).

Function
REQ-015 SHALL be a 2-entry in-order skid buffer between fetch and decode, each entry holding {pc, pc_plus4, instr}.
REQ-016 SHALL implement states EMPTY, ONE and FULL, with occupancy equal to 0, 1 and 2 respectively.
REQ-017 SHALL define enq = in_valid & in_ready and deq = out_valid & out_ready.
REQ-018 SHALL drive in_ready = (state != FULL) from registered state only, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (state != EMPTY).
REQ-020 SHALL use these transitions when flush=0: EMPTY+enq goes to ONE; ONE+enq without deq goes to FULL; ONE+deq without enq goes to EMPTY; ONE+enq+deq stays ONE; FULL+deq goes to ONE; all other cases hold state.
REQ-021 SHALL present, on ONE+enq+deq, the newly enqueued entry as head on the next cycle.
REQ-022 SHALL promote the second entry to head on FULL+deq, preserving order.
REQ-023 SHALL go to EMPTY on the next edge when flush=1, regardless of state, in_valid or out_ready.
REQ-024 SHALL discard any entry enqueued in the same cycle as flush.
REQ-025 SHALL treat flush as not affecting the deq of the current head, which decode may still take in that cycle.
REQ-026 SHALL drive out_pc=0, out_pc_plus4=0 and out_instr=NOP_WORD while out_valid=0.
REQ-027 SHALL give a latency of exactly 1 cycle from enq into EMPTY to out_valid=1 with that entry.
REQ-028 SHALL pass all data bits through unmodified, with no arithmetic and no truncation.
REQ-029 SHALL hold head entry fields stable while out_valid=1 and out_ready=0.
REQ-030 SHALL ignore in_* data when in_valid=0 or in_ready=0.

Reset
REQ-031 SHALL, when reset=1 at a rising edge, set state to EMPTY and occupancy to 0, and clear all entry storage to pc=0, pc_plus4=0, instr=NOP_WORD.
REQ-032 SHALL have reset take priority over flush, enq and deq.
REQ-033 SHALL drive in_ready=1 and out_valid=0 in the cycle after reset.
REQ-034 SHALL, on reset mid-operation, drop in-flight entries without emitting them.

Structure
REQ-035 SHALL take the state encoding (EMPTY/ONE/FULL typedef), the XLEN default and the NOP_WORD constant from a shared pipeline package.
REQ-036 SHALL be a single module, with entry storage as two register sets (head, tail) and no sub-module.
REQ-037 SHALL infer no latches and SHALL contain no combinational loop between the in_ready and out_ready handshakes.

Verification
REQ-038 SHALL cover reset: reset=1 for 2 cycles -> occupancy=0, out_valid=0, out_instr=0x00000000, in_ready=1.
REQ-039 SHALL cover single pass: enq pc=0x00000010, instr=0x8C080004, out_ready=1 -> next cycle out_valid=1, out_pc=0x10, out_pc_plus4=0x14, then EMPTY.
REQ-040 SHALL cover backpressure: out_ready=0 with 3 back-to-back in_valid pulses (pc 0x0, 0x4, 0x8) -> in_ready=0 after the 2nd, occupancy=2; release out_ready -> pc 0x0 then 0x4 are emitted in order, and 0x8 is accepted only once in_ready returns to 1.
REQ-041 SHALL cover streaming: continuous in_valid and out_ready=1 -> occupancy stays 1, one entry output per cycle, PCs consecutive +4.
REQ-042 SHALL cover flush with enqueue: FULL plus flush=1 with in_valid=1 (pc 0x20) -> next cycle occupancy=0 and pc 0x20 is never output.
REQ-043 SHALL cover reset during FULL with out_ready=1 -> no entry is output after the reset edge and occupancy=0.

Source files
------------

// File: rtl/fetch_decode_buffer_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: datapath width,
// the instruction word used as a bubble, and the skid-buffer state encoding.
package fetch_decode_buffer_pkg;

  // Default datapath width for PC and instruction fields.
  localparam int XLEN_DEFAULT = 32;

  // Instruction word presented to decode when no entry is valid.
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Buffer state. The encoding equals the number of valid entries, so the
  // state register doubles as the occupancy count. 2'b11 is never reached.
  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

endpackage : fetch_decode_buffer_pkg

// File: rtl/fetch_decode_buffer.sv
// Two-entry in-order skid buffer between fetch and decode. Each entry holds
// {pc, pc_plus4, instr}. in_ready depends on registered state only, which
// breaks the ready path between the two stages. A flush drops every entry
// that is not being taken by decode in the same cycle.
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_WORD_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [XLEN-1:0] out_instr,
  input  logic            flush,
  output logic [1:0]      occupancy
);

  state_t state;

  // Head is the entry shown to decode; tail holds the entry that arrived
  // while decode was stalled.
  logic [XLEN-1:0] head_pc, head_pc_plus4, head_instr;
  logic [XLEN-1:0] tail_pc, tail_pc_plus4, tail_instr;

  logic enq;
  logic deq;

  // Handshakes are derived from registered state only, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  // State and entry storage update; reset beats flush, flush beats enq/deq.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (reset) begin
      // NOTE: entry storage is cleared on reset so a freshly reset buffer
      // never holds stale words from before the reset.
      state         <= ST_EMPTY;
      head_pc       <= '0;
      head_pc_plus4 <= '0;
      head_instr    <= NOP_WORD;
      tail_pc       <= '0;
      tail_pc_plus4 <= '0;
      tail_instr    <= NOP_WORD;
    end else if (flush) begin
      // Any entry enqueued this cycle is discarded; a head taken by decode
      // this cycle has already been consumed through deq.
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (enq) begin
            head_pc       <= in_pc;
            head_pc_plus4 <= in_pc_plus4;
            head_instr    <= in_instr;
            state         <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (enq && deq) begin
            // Head leaves while the new entry arrives: it becomes head.
            head_pc       <= in_pc;
            head_pc_plus4 <= in_pc_plus4;
            head_instr    <= in_instr;
          end else if (enq) begin
            tail_pc       <= in_pc;
            tail_pc_plus4 <= in_pc_plus4;
            tail_instr    <= in_instr;
            state         <= ST_FULL;
          end else if (deq) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a dequeue can change anything.
          if (deq) begin
            head_pc       <= tail_pc;
            head_pc_plus4 <= tail_pc_plus4;
            head_instr    <= tail_instr;
            state         <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Present the head entry to decode, or a bubble when nothing is valid.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    out_pc       = '0;
    out_pc_plus4 = '0;
    out_instr    = NOP_WORD;
    if (out_valid) begin
      out_pc       = head_pc;
      out_pc_plus4 = head_pc_plus4;
      out_instr    = head_instr;
    end
  end

endmodule : fetch_decode_buffer
